// File: rtl/seq_data_compare.sv
// rtl/seq_data_compare.sv - multi-cycle chunked magnitude comparator, MSB chunk first, early exit
module seq_data_compare #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic                                 iStart,
    input  logic                                 iSigned,
    input  logic [WIDTH-1:0]                     iData_a,
    input  logic [WIDTH-1:0]                     iData_b,
    output logic                                 oBusy,
    output logic                                 oDone,
    output logic [2:0]                           oData,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]     oCount
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int PW     = $clog2(NCHUNK);
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [PW-1:0] PTR_TOP = PW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             a_gt;
    logic             a_lt;
    logic [CW-1:0]    cnt_inc;

    // Chunk select as an explicit mux keeps the per-cycle logic depth to one chunk compare.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (ptr == PW'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (sgn_q && (ptr == PTR_TOP)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
        a_gt    = chunk_a > chunk_b;
        a_lt    = chunk_a < chunk_b;
        cnt_inc = cnt + CW'(1);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            ptr    <= '0;
            cnt    <= '0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oData  <= 3'b000;
            oCount <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        a_q   <= iData_a;
                        b_q   <= iData_b;
                        sgn_q <= iSigned;
                        ptr   <= PTR_TOP;
                        cnt   <= '0;
                        oBusy <= 1'b1;
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    cnt <= cnt_inc;
                    if (a_gt || a_lt || (ptr == '0)) begin
                        if (a_gt) begin
                            oData <= 3'b100;
                        end else if (a_lt) begin
                            oData <= 3'b010;
                        end else begin
                            oData <= 3'b001;
                        end
                        oCount <= cnt_inc;
                        oDone  <= 1'b1;
                        oBusy  <= 1'b0;
                        state  <= DONE;
                    end else begin
                        ptr <= ptr - PW'(1);
                    end
                end
                default: begin
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
